// File: rtl/pll_hdmi_drp_ctrl.sv
// pll_hdmi_drp_ctrl: DRP read-modify-write sequencer that retunes the HDMI pixel-clock PLLE2_ADV.
// Define PLL_HDMI_DRP_READBACK_EN to re-read and verify all five registers before releasing reset.
module pll_hdmi_drp_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_mult,
  input  logic [7:0]  cfg_div0,
  input  logic [5:0]  cfg_divclk,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CHECK     = 4'd1;
  localparam logic [3:0] RST_HOLD  = 4'd2;
  localparam logic [3:0] RD_REQ    = 4'd3;
  localparam logic [3:0] RD_WAIT   = 4'd4;
  localparam logic [3:0] WR_REQ    = 4'd5;
  localparam logic [3:0] WR_WAIT   = 4'd6;
  localparam logic [3:0] RELEASE   = 4'd7;
  localparam logic [3:0] LOCK_WAIT = 4'd8;
  localparam logic [3:0] FINISH    = 4'd9;
`ifdef PLL_HDMI_DRP_READBACK_EN
  localparam logic [3:0] VF_REQ    = 4'd10;
  localparam logic [3:0] VF_WAIT   = 4'd11;
  logic [15:0] wv [5];
`endif
  logic [3:0]  state;
  logic [6:0]  mult_q;
  logic [7:0]  div0_q;
  logic [5:0]  divclk_q;
  logic [2:0]  idx;
  logic [15:0] rdata;
  logic [19:0] cnt;
  logic        rst_q;
  logic [2:0]  err;
  logic [13:0] enc_mult, enc_div0, enc_divclk;
  logic [15:0] keep, newv, wdata;
  logic [6:0]  addr;
  logic        range_ok, drdy_to, lock_to, rd_req;
  // {edge, nocnt, high[5:0], low[5:0]}; a count of 64 wraps to 0 in the 6-bit fields
  function automatic logic [13:0] enc(input logic [7:0] d);
    return (d == 8'd1) ? {2'b11, 6'd1, 6'd1} : {d[0], 1'b0, d[6:1], d[6:1] + {5'b0, d[0]}};
  endfunction
  always_comb begin
    enc_mult   = enc({1'b0, mult_q});
    enc_div0   = enc(div0_q);
    enc_divclk = enc({2'b0, divclk_q});
    addr  = idx == 3'd0 ? 7'h08 : idx == 3'd1 ? 7'h09 : idx == 3'd2 ? 7'h14 : idx == 3'd3 ? 7'h15 : 7'h16;
    keep  = (idx == 3'd0 || idx == 3'd2) ? 16'h1000 : (idx == 3'd1 || idx == 3'd3) ? 16'hFF00 : 16'hC000;
    newv  = idx == 3'd0 ? {4'b0, enc_div0[11:0]} :
            idx == 3'd1 ? {8'b0, enc_div0[13:12], 6'b0} :
            idx == 3'd2 ? {4'b0, enc_mult[11:0]} :
            idx == 3'd3 ? {8'b0, enc_mult[13:12], 6'b0} : {2'b0, enc_divclk};
    wdata = (rdata & keep) | newv;
    range_ok = mult_q >= 7'd2 && mult_q <= 7'd64 && div0_q != 8'd0 && div0_q <= 8'd128 &&
               divclk_q != 6'd0 && divclk_q <= 6'd56;
    drdy_to = cnt == 20'(DRDY_TIMEOUT - 1);
    lock_to = cnt == 20'(LOCK_TIMEOUT - 1);
`ifdef PLL_HDMI_DRP_READBACK_EN
    rd_req = state == RD_REQ || state == VF_REQ;
`else
    rd_req = state == RD_REQ;
`endif
  end
  assign cfg_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == FINISH;
  assign err_code  = err;
  assign pll_rst   = rst_q;
  assign drp_den   = rd_req || state == WR_REQ;
  assign drp_dwe   = state == WR_REQ;
  assign drp_daddr = drp_den ? addr : 7'd0;
  assign drp_di    = drp_dwe ? wdata : 16'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rst_q <= 1'b0;
      err   <= 3'd0;
      idx   <= 3'd0;
      cnt   <= 20'd0;
      rdata <= 16'd0;
    end else begin
      cnt <= cnt + 20'd1;
      case (state)
        IDLE: if (cfg_valid) begin
          mult_q   <= cfg_mult;
          div0_q   <= cfg_div0;
          divclk_q <= cfg_divclk;
          state    <= CHECK;
        end
        CHECK: begin
          cnt   <= 20'd0;
          idx   <= 3'd0;
          rst_q <= range_ok;
          err   <= range_ok ? err : 3'd1;
          state <= range_ok ? RST_HOLD : FINISH;
        end
        RST_HOLD: if (cnt == 20'(RST_CYCLES - 1)) state <= RD_REQ;
        RD_REQ: begin
          cnt   <= 20'd0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (drp_drdy) begin
          rdata <= drp_do;
          state <= WR_REQ;
        end else if (drdy_to) begin
          rst_q <= 1'b0;
          err   <= 3'd2;
          state <= FINISH;
        end
        WR_REQ: begin
`ifdef PLL_HDMI_DRP_READBACK_EN
          wv[idx] <= wdata;
`endif
          cnt   <= 20'd0;
          state <= WR_WAIT;
        end
        WR_WAIT: if (drp_drdy) begin
          if (idx == 3'd4) begin
`ifdef PLL_HDMI_DRP_READBACK_EN
            idx   <= 3'd0;
            state <= VF_REQ;
`else
            rst_q <= 1'b0;
            state <= RELEASE;
`endif
          end else begin
            idx   <= idx + 3'd1;
            state <= RD_REQ;
          end
        end else if (drdy_to) begin
          rst_q <= 1'b0;
          err   <= 3'd2;
          state <= FINISH;
        end
`ifdef PLL_HDMI_DRP_READBACK_EN
        VF_REQ: begin
          cnt   <= 20'd0;
          state <= VF_WAIT;
        end
        VF_WAIT: if (drp_drdy) begin
          if (drp_do != wv[idx]) begin
            rst_q <= 1'b0;
            err   <= 3'd4;
            state <= FINISH;
          end else if (idx == 3'd4) begin
            rst_q <= 1'b0;
            state <= RELEASE;
          end else begin
            idx   <= idx + 3'd1;
            state <= VF_REQ;
          end
        end else if (drdy_to) begin
          rst_q <= 1'b0;
          err   <= 3'd2;
          state <= FINISH;
        end
`endif
        RELEASE: begin
          cnt   <= 20'd0;
          state <= LOCK_WAIT;
        end
        LOCK_WAIT: if (pll_locked || lock_to) begin
          err   <= pll_locked ? 3'd0 : 3'd3;
          state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_hdmi_drp_ctrl.sv
// tb_pll_hdmi_drp_ctrl: scoreboard bench with a DRP/PLL responder model for pll_hdmi_drp_ctrl.
module tb_pll_hdmi_drp_ctrl;
  logic        clk = 0, rst = 1, cfg_valid = 0;
  logic        cfg_ready, drp_den, drp_dwe, drp_drdy, pll_rst, pll_locked, busy, done;
  logic [6:0]  cfg_mult = 0, drp_daddr;
  logic [7:0]  cfg_div0 = 0;
  logic [5:0]  cfg_divclk = 0;
  logic [15:0] drp_di, drp_do;
  logic [2:0]  err_code;

  pll_hdmi_drp_ctrl #(.RST_CYCLES(4), .DRDY_TIMEOUT(255), .LOCK_TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mult(cfg_mult), .cfg_div0(cfg_div0), .cfg_divclk(cfg_divclk),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .pll_rst(pll_rst), .pll_locked(pll_locked),
    .busy(busy), .done(done), .err_code(err_code)
  );

`ifdef PLL_HDMI_DRP_READBACK_EN
  localparam int NTX = 15;
`else
  localparam int NTX = 10;
`endif

  int total = 0, bad = 0;
  int cyc = 0, txn = 0, mon_n = 0, rsp_n = 0, done_cnt = 0;
  int done_cyc = 0, acc_cyc = 0, t3_cyc = 0, fall_cyc = 0;
  int lat = 2, drop = 0, lock_delay = 10;
  bit corrupt = 0, rst_seen = 0, prev_den = 0, prev_rst = 0;
  logic [15:0] mem [128];
  logic [22:0] exp_wq [$];
  logic [2:0]  err_q [$];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_hl(input int d);
    int h, l;
    h = (d == 1) ? 1 : d / 2;
    l = (d == 1) ? 1 : d - h;
    return 16'(((h % 64) << 6) | (l % 64));
  endfunction

  function automatic logic [15:0] enc_en(input int d);
    return 16'(((d % 2) << 7) | ((d == 1) ? 64 : 0));
  endfunction

  task automatic req(input int m, input int d0, input int dc, input int er, input int nw);
    logic [22:0] w [5];
    for (int a = 0; a < 128; a++) mem[a] = 16'hFFFF;
    w[0] = {7'h08, 16'h1000 | enc_hl(d0)};
    w[1] = {7'h09, 16'hFF00 | enc_en(d0)};
    w[2] = {7'h14, 16'h1000 | enc_hl(m)};
    w[3] = {7'h15, 16'hFF00 | enc_en(m)};
    w[4] = {7'h16, 16'hC000 | (enc_en(dc) << 6) | enc_hl(dc)};
    for (int i = 0; i < nw; i++) exp_wq.push_back(w[i]);
    err_q.push_back(3'(er));
    mon_n = 0;
    rsp_n = 0;
    @(negedge clk);
    cfg_mult = 7'(m);
    cfg_div0 = 8'(d0);
    cfg_divclk = 6'(dc);
    cfg_valid = 1;
    acc_cyc = cyc;
    check("req_ready", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("wq_left", exp_wq.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_den"}, drp_den, 0);
    check({tag, "_dwe"}, drp_dwe, 0);
    check({tag, "_daddr"}, drp_daddr, 0);
    check({tag, "_di"}, drp_di, 0);
    check({tag, "_pllrst"}, pll_rst, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_code, 0);
  endtask

  // DRP slave and PLL lock model
  initial begin
    int cd, lcd;
    logic [15:0] rv;
    cd = 0;
    lcd = 0;
    rv = 0;
    drp_drdy = 0;
    drp_do = 0;
    pll_locked = 0;
    forever begin
      @(posedge clk);
      #1;
      drp_drdy = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          drp_drdy = 1;
          drp_do = rv;
        end
      end
      if (drp_den) begin
        rsp_n++;
        if (drp_dwe) mem[drp_daddr] = drp_di;
        rv = mem[drp_daddr];
        if (corrupt && rsp_n > 10 && drp_daddr == 7'h15) rv = rv ^ 16'h0001;
        cd = (rsp_n == drop) ? 0 : lat;
      end
      if (pll_rst) begin
        pll_locked = 0;
        lcd = lock_delay;
      end else if (lcd > 0) begin
        lcd--;
        if (lcd == 0) pll_locked = 1;
      end
    end
  end

  // Output monitor: protocol checks and scoreboard pops
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pll_rst) rst_seen = 1;
        if (prev_rst && !pll_rst) fall_cyc = cyc;
        if (drp_den) begin
          check("den_gap", prev_den, 0);
          txn++;
          mon_n++;
          if (mon_n == 3) t3_cyc = cyc;
          if (drp_dwe) begin
            check("wr_q", exp_wq.size() > 0, 1);
            if (exp_wq.size() > 0) begin
              e = exp_wq.pop_front();
              check("wr_addr", drp_daddr, e[22:16]);
              check("wr_data", drp_di, e[15:0]);
            end
            check("wr_pllrst", pll_rst, 1);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_q", err_q.size() > 0, 1);
          if (err_q.size() > 0) check("err_code", err_code, err_q.pop_front());
        end
      end
      prev_den = drp_den;
      prev_rst = pll_rst;
    end
  end

  initial begin
    int t0, n;
    int rng [5][3] = '{'{1, 17, 1}, '{25, 17, 0}, '{65, 17, 1}, '{25, 0, 1}, '{25, 17, 57}};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;

    t0 = txn;
    req(25, 17, 1, 0, 5);
    wait_done(2000);
    check("nominal_txn", txn - t0, NTX);
    check("nominal_pllrst", pll_rst, 0);

    req(64, 128, 56, 0, 5);
    wait_done(2000);

    // drdy arrives on the last allowed wait cycle of every transaction
    lat = 255;
    req(10, 5, 3, 0, 5);
    wait_done(8000);
    lat = 2;

    for (int i = 0; i < 5; i++) begin
      t0 = txn;
      rst_seen = 0;
      req(rng[i][0], rng[i][1], rng[i][2], 1, 0);
      wait_done(20);
      check("range_latency", done_cyc - acc_cyc, 2);
      check("range_den", txn - t0, 0);
      check("range_pllrst", rst_seen, 0);
    end

    drop = 3;
    req(25, 17, 1, 2, 1);
    wait_done(2000);
    check("drdy_to_latency", done_cyc - t3_cyc, 256);
    check("drdy_to_pllrst", pll_rst, 0);
    drop = 0;

    lock_delay = 0;
    req(30, 9, 2, 3, 5);
    repeat (3) @(negedge clk);
    cfg_valid = 1;
    cfg_mult = 7'd40;
    check("busy_ready", cfg_ready, 0);
    check("busy_busy", busy, 1);
    @(negedge clk);
    cfg_valid = 0;
    wait_done(2000);
    check("lock_to_latency", done_cyc - fall_cyc, 201);
    lock_delay = 10;

    req(25, 17, 1, 0, 5);
    n = 0;
    while (!(drp_den && drp_dwe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_write_seen", drp_den && drp_dwe, 1);
    rst = 1;
    @(negedge clk);
    check_idle("midrst");
    rst = 0;
    repeat (20) @(negedge clk);
    check("midrst_nodone", err_q.size(), 1);
    exp_wq.delete();
    err_q.delete();

    t0 = txn;
    req(40, 8, 2, 0, 5);
    wait_done(2000);
    check("recover_txn", txn - t0, NTX);

`ifdef PLL_HDMI_DRP_READBACK_EN
    corrupt = 1;
    t0 = txn;
    req(25, 17, 1, 4, 5);
    wait_done(2000);
    check("readback_txn", txn - t0, 14);
    check("readback_pllrst", pll_rst, 0);
    corrupt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
